regfile_debug_access: RTL and testbench
=======================================

Name: regfile_debug_access

Overview:
Debug-side access engine for the RISC-V single-cycle core's 32x32 register file. It accepts read/write requests from a debug host over a valid/ready handshake and requests a core halt. Once the core acknowledges the halt, it performs exactly one register-file access and returns the response over a second valid/ready channel. It sits between the debug transport and the register-file port mux: it drives the read address and write port while the core is halted, and consumes the read-data output.

Parameters:
HALT_TIMEOUT, 16, max cycles to wait for halted after halt_req rises; 0 = wait forever
CNT_W, $clog2(HALT_TIMEOUT+1) (min 1), width of the timeout counter (derived; do not override)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  host request valid
req_ready  output  1  block can accept a request
req_write  input  1  1 = write, 0 = read
req_addr  input  5  register index x0..x31
req_wdata  input  32  write data
resp_valid  output  1  response valid
resp_ready  input  1  host accepts response
resp_rdata  output  32  read data (0 for writes and errors)
resp_err  output  1  halt timeout; no access performed
halt_req  output  1  request core stall
halted  input  1  core is stalled; register-file port is free
rf_ra  output  5  register-file read address (muxed onto read port 1 while halted)
rf_rd  input  32  register-file read data (combinational from rf_ra)
rf_we  output  1  register-file write enable
rf_wa  output  5  register-file write address
rf_wd  output  32  register-file write data

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- States: IDLE, WAIT_HALT, ACCESS, RESP. Reset puts the block in IDLE.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, halt_req=0, rf_we=0, rf_ra=0, rf_wa=0, rf_wd=0, counter=0.
- req_ready=1 only in IDLE. A request is accepted on a clock edge where req_valid&&req_ready.
- On acceptance: capture write/addr/wdata, clear the counter, go to WAIT_HALT.
- halt_req is registered. It is 1 in WAIT_HALT, ACCESS and RESP, and falls in the cycle after the resp handshake.
- WAIT_HALT:
  - If halted=1, go to ACCESS next cycle.
  - Else if HALT_TIMEOUT!=0 and counter==HALT_TIMEOUT-1, go to RESP with resp_err=1 and resp_rdata=0.
  - Else the counter increments.
  - halted is also checked in the first WAIT_HALT cycle.
- ACCESS (exactly one cycle):
  - rf_ra, rf_wa and rf_wd carry the captured address and data.
  - rf_we = write && addr!=0 && !reset. A write to x0 is dropped silently with err=0.
  - Reads: rf_rd is registered into resp_rdata at the end of the cycle.
  - Writes: resp_rdata=0.
  - Then go to RESP with resp_err=0.
- RESP: resp_valid=1, and resp_rdata/resp_err stay stable until resp_ready. On the handshake, go to IDLE next cycle (resp_valid=0, halt_req=0).
- Minimum latency with halted tied high: accept at edge T, ACCESS during cycle T+2, resp_valid high from T+3. Back-to-back requests need ≥1 IDLE cycle between them.
- If halted drops during ACCESS, the access still completes. The block never re-checks halted after WAIT_HALT.
- Reset in any state returns to IDLE within one edge. Reset asserted during the ACCESS cycle suppresses rf_we, so no partial write occurs. Any pending response is discarded.
- rf_ra/rf_wa/rf_wd hold the captured values outside ACCESS. Only rf_we qualifies a write.

Test Plan:
- Write then read: halted tied 1; write x5=0xDEADBEEF → rf_we pulses 1 cycle with wa=5, wd=0xDEADBEEF; resp_valid at T+3 with err=0. Read x5 → resp_rdata=0xDEADBEEF.
- x0 handling: write x0=0xFFFFFFFF → rf_we stays 0, err=0. Read x0 → rdata=0.
- Halt delay: halted rises 7 cycles after halt_req → ACCESS occurs the cycle after halted is seen, err=0, and req_ready=0 throughout.
- Timeout: HALT_TIMEOUT=4, halted held 0 → resp_valid with err=1 and rdata=0 after exactly 4 WAIT_HALT cycles; rf_we never asserts; halt_req drops after the handshake.
- Backpressure: resp_ready held 0 for 10 cycles → resp_valid/rdata/err stable, halt_req stays 1, req_valid is ignored.
- Reset mid-op: assert reset during the ACCESS cycle of a write x3=0x1234 → rf_we=0 that cycle; next cycle IDLE with all outputs at reset values; a later read of x3 returns the prior value.

Source files
------------

// File: rtl/regfile_debug_access.sv
// Debug-side access engine for the core register file.
// Takes one read/write request from the debug host, stalls the core,
// performs a single register-file access while halted, and returns the
// result on a separate response channel.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   IDLE      | ready for a host request, core not stalled by us
//   WAIT_HALT | halt_req raised, waiting for halted (bounded by timeout)
//   ACCESS    | one cycle driving the register-file ports
//   RESP      | response held until the host takes it
module regfile_debug_access #(
    parameter int HALT_TIMEOUT = 16,
    localparam int CNT_W = (HALT_TIMEOUT > 0) ? $clog2(HALT_TIMEOUT + 1) : 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        halt_req,
    input  logic        halted,
    output logic [4:0]  rf_ra,
    input  logic [31:0] rf_rd,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HALT,
        ACCESS,
        RESP
    } state_t;

    // Terminal count of the halt wait; unused when the timeout is disabled.
    localparam logic [CNT_W-1:0] TC = (HALT_TIMEOUT > 0) ? CNT_W'(HALT_TIMEOUT - 1) : '0;

    state_t            state;
    state_t            state_next;
    logic              cap_write;
    logic [4:0]        cap_addr;
    logic [31:0]       cap_wdata;
    logic [CNT_W-1:0]  count;
    logic              accept;
    logic              resp_done;
    logic              timeout_hit;

    assign accept      = req_valid && req_ready;
    assign resp_done   = resp_valid && resp_ready;
    assign timeout_hit = (HALT_TIMEOUT != 0) && (count == TC);

    // The register-file address/data ports simply show the captured request;
    // rf_we alone decides whether a write happens.
    assign rf_ra = cap_addr;
    assign rf_wa = cap_addr;
    assign rf_wd = cap_wdata;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and combinational handshake/write-enable outputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        rf_we      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    state_next = WAIT_HALT;
                end
            end
            WAIT_HALT: begin
                if (halted) begin
                    state_next = ACCESS;
                end else if (timeout_hit) begin
                    state_next = RESP;
                end
            end
            ACCESS: begin
                // Reset in this cycle must not leave a partial write behind.
                rf_we      = cap_write && (cap_addr != 5'd0) && !reset;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture, halt request, timeout counter and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_write  <= 1'b0;
            cap_addr   <= 5'd0;
            cap_wdata  <= 32'd0;
            count      <= '0;
            halt_req   <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_write <= req_write;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        count     <= '0;
                        halt_req  <= 1'b1;
                    end
                end
                WAIT_HALT: begin
                    // halted wins over the timeout in the same cycle.
                    if (!halted) begin
                        if (timeout_hit) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    resp_rdata <= cap_write ? 32'd0 : rf_rd;
                    resp_err   <= 1'b0;
                end
                RESP: begin
                    if (resp_done) begin
                        halt_req   <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    halt_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_debug_access.sv
// Scoreboard bench for regfile_debug_access: a driver issues host requests and
// pushes expected responses/writes; monitors pop and compare on DUT outputs.
module tb_regfile_debug_access;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [4:0]  req_addr = 5'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        halt_req;
    logic        halted = 1'b0;
    logic [4:0]  rf_ra;
    logic [31:0] rf_rd;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    // second instance with a short timeout, halted never asserted
    logic        req_valid2 = 1'b0;
    logic        req_ready2;
    logic        req_write2 = 1'b0;
    logic [4:0]  req_addr2 = 5'd0;
    logic [31:0] req_wdata2 = 32'd0;
    logic        resp_valid2;
    logic        resp_ready2 = 1'b0;
    logic [31:0] resp_rdata2;
    logic        resp_err2;
    logic        halt_req2;
    logic        halted2 = 1'b0;
    logic [4:0]  rf_ra2;
    logic [31:0] rf_rd2;
    logic        rf_we2;
    logic [4:0]  rf_wa2;
    logic [31:0] rf_wd2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] env_mem [32];
    logic [31:0] ref_rf [32];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          first;
    } exp_t;
    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
    } wexp_t;

    exp_t  sbq[$];
    wexp_t wq[$];

    bit          busy = 1'b0;
    bit          mon_en = 1'b0;
    bit          seen = 1'b0;
    bit          prev_stall = 1'b0;
    bit          hold_ready = 1'b0;
    logic [31:0] prev_rdata = 32'd0;
    logic        prev_err = 1'b0;

    regfile_debug_access #(.HALT_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .halt_req(halt_req), .halted(halted),
        .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    regfile_debug_access #(.HALT_TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write2),
        .req_addr(req_addr2), .req_wdata(req_wdata2),
        .resp_valid(resp_valid2), .resp_ready(resp_ready2),
        .resp_rdata(resp_rdata2), .resp_err(resp_err2),
        .halt_req(halt_req2), .halted(halted2),
        .rf_ra(rf_ra2), .rf_rd(rf_rd2), .rf_we(rf_we2), .rf_wa(rf_wa2), .rf_wd(rf_wd2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Register file as seen by the core: x0 reads zero and ignores writes.
    assign rf_rd  = (rf_ra == 5'd0) ? 32'd0 : env_mem[rf_ra];
    assign rf_rd2 = {27'd0, rf_ra2};

    always @(posedge clk) begin
        if (rf_we && rf_wa != 5'd0) env_mem[rf_wa] = rf_wd;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string msg);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d", msg, cyc);
    endtask

    // Host response-ready: random unless a backpressure window is requested.
    always @(posedge clk) begin
        #1;
        resp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Write monitor: every rf_we cycle must match the next expected write.
    always @(negedge clk) begin
        if (rf_we) begin
            if (wq.size() == 0) begin
                fail_now($sformatf("rf_we unexpected: got wa=%0d wd=%h required no write", rf_wa, rf_wd));
            end else begin
                chk("rf_wa", 32'(rf_wa), 32'(wq[0].wa));
                chk("rf_wd", rf_wd, wq[0].wd);
                void'(wq.pop_front());
            end
        end
        if (rf_we2) begin
            fail_now($sformatf("rf_we2 during timeout: got wa=%0d wd=%h required no write", rf_wa2, rf_wd2));
        end
    end

    // Response monitor: handshake signals, stability under stall, latency and data.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("halt_req", 32'(halt_req), 32'(busy));
            chk("req_ready", 32'(req_ready), 32'(!busy));
            if (prev_stall) begin
                chk("resp_valid_hold", 32'(resp_valid), 32'd1);
                chk("resp_rdata_hold", resp_rdata, prev_rdata);
                chk("resp_err_hold", 32'(resp_err), 32'(prev_err));
            end
            if (resp_valid) begin
                if (sbq.size() == 0) begin
                    fail_now("resp_valid with no request pending: got 1 required 0");
                end else begin
                    if (!seen) begin
                        chk("resp_latency", 32'(cyc), 32'(sbq[0].first));
                        seen = 1'b1;
                    end
                    if (resp_ready) begin
                        chk("resp_rdata", resp_rdata, sbq[0].rdata);
                        chk("resp_err", 32'(resp_err), 32'(sbq[0].err));
                        void'(sbq.pop_front());
                        seen = 1'b0;
                        busy = 1'b0;
                    end
                end
            end
            prev_stall = resp_valid && !resp_ready;
            prev_rdata = resp_rdata;
            prev_err   = resp_err;
        end
    end

    // Issue one request; halted rises d WAIT_HALT cycles after acceptance.
    // Called at posedge+1 with the DUT idle.
    task automatic issue(input logic w, input logic [4:0] a, input logic [31:0] wd,
                         input int d, input logic drop);
        exp_t  e;
        wexp_t we;
        logic  ok;
        int    k;
        req_write = w;
        req_addr  = a;
        req_wdata = wd;
        req_valid = 1'b1;
        halted    = 1'b0;
        @(posedge clk); #1;
        busy    = 1'b1;
        ok      = (TO == 0) || (d < TO);
        e.err   = !ok;
        e.rdata = (ok && !w) ? ((a == 5'd0) ? 32'd0 : ref_rf[a]) : 32'd0;
        e.first = cyc + (ok ? d + 2 : TO);
        sbq.push_back(e);
        if (ok && w && a != 5'd0) begin
            we.wa = a;
            we.wd = wd;
            wq.push_back(we);
            ref_rf[a] = wd;
        end
        halted = (d == 0);
        k = 0;
        while (busy) begin
            req_valid = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
            req_addr  = 5'($urandom);
            req_wdata = $urandom;
            @(posedge clk); #1;
            k++;
            if (k == d) halted = 1'b1;
            if (drop && k == d + 1) halted = 1'b0;
            if (k > 500) begin
                $display("FAIL issue_bound: no response handshake after %0d cycles, required one", k);
                $fatal(1);
            end
        end
        req_valid = 1'b0;
        halted    = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic found;
        int   a0;
        int   bp;

        for (int i = 0; i < 32; i++) begin
            env_mem[i] = (i == 0) ? 32'd0 : $urandom;
            ref_rf[i]  = env_mem[i];
        end

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_halt_req", 32'(halt_req), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_ra", 32'(rf_ra), 32'd0);
        chk("rst_rf_wa", 32'(rf_wa), 32'd0);
        chk("rst_rf_wd", rf_wd, 32'd0);
        chk("rst_req_ready2", 32'(req_ready2), 32'd1);
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Timeout on the short-timeout instance: exactly 4 WAIT_HALT cycles.
        req_write2 = 1'b1;
        req_addr2  = 5'd7;
        req_wdata2 = 32'hCAFEF00D;
        req_valid2 = 1'b1;
        @(posedge clk); #1;
        a0 = cyc;
        req_valid2 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (resp_valid2) begin
                found = 1'b1;
                break;
            end
            chk("to_halt_req_wait", 32'(halt_req2), 32'd1);
        end
        if (!found) begin
            fail_now("to_response: got no resp_valid2 required one");
        end else begin
            chk("to_latency", 32'(cyc), 32'(a0 + 4));
            chk("to_err", 32'(resp_err2), 32'd1);
            chk("to_rdata", resp_rdata2, 32'd0);
            chk("to_halt_req", 32'(halt_req2), 32'd1);
        end
        @(posedge clk); #1;
        resp_ready2 = 1'b1;
        @(negedge clk);
        chk("to_valid_at_hs", 32'(resp_valid2), 32'd1);
        @(posedge clk); #1;
        resp_ready2 = 1'b0;
        @(negedge clk);
        chk("to_halt_req_drop", 32'(halt_req2), 32'd0);
        chk("to_valid_drop", 32'(resp_valid2), 32'd0);
        @(posedge clk); #1;

        // Directed: write/read, x0, halt delay, timeout boundary.
        issue(1'b1, 5'd5, 32'hDEADBEEF, 0, 1'b0);
        issue(1'b0, 5'd5, 32'd0, 0, 1'b0);
        issue(1'b1, 5'd0, 32'hFFFFFFFF, 0, 1'b0);
        issue(1'b0, 5'd0, 32'd0, 0, 1'b0);
        issue(1'b0, 5'd5, 32'd0, 7, 1'b0);
        issue(1'b1, 5'd9, 32'h0BADF00D, TO - 1, 1'b1);
        issue(1'b1, 5'd9, 32'h11111111, TO, 1'b0);
        issue(1'b0, 5'd9, 32'd0, 2, 1'b1);

        // Backpressure: response withheld for 10 cycles.
        hold_ready = 1'b1;
        fork
            issue(1'b0, 5'd5, 32'd0, 1, 1'b0);
            begin
                bp = 0;
                while (!resp_valid && bp < 50) begin
                    @(negedge clk);
                    bp++;
                end
                repeat (10) @(negedge clk);
                chk("bp_valid", 32'(resp_valid), 32'd1);
                chk("bp_halt_req", 32'(halt_req), 32'd1);
                chk("bp_req_ready", 32'(req_ready), 32'd0);
                hold_ready = 1'b0;
            end
        join

        // Reset during the ACCESS cycle of a write to x3.
        idle_cycles(1);
        mon_en    = 1'b0;
        req_write = 1'b1;
        req_addr  = 5'd3;
        req_wdata = 32'h00001234;
        req_valid = 1'b1;
        halted    = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_rf_we", 32'(rf_we), 32'd0);
        @(posedge clk); #1;
        reset  = 1'b0;
        halted = 1'b0;
        @(negedge clk);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mid_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mid_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mid_halt_req", 32'(halt_req), 32'd0);
        chk("rst_mid_rf_wa", 32'(rf_wa), 32'd0);
        chk("rst_mid_rf_wd", rf_wd, 32'd0);
        @(posedge clk); #1;
        busy       = 1'b0;
        seen       = 1'b0;
        prev_stall = 1'b0;
        mon_en     = 1'b1;
        issue(1'b0, 5'd3, 32'd0, 0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            logic       w;
            logic [4:0] a;
            int         d;
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            d = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : $urandom_range(TO - 3, TO + 2);
            issue(w, a, $urandom, d, 1'($urandom_range(0, 1)));
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(3);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        chk("writes_drained", 32'(wq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
